// File: rtl/gpio_int_ctrl.sv
// CPU-domain interrupt controller: latches CDC pulses into W1C pending bits, masks them,
// and drives a level interrupt with a guaranteed low gap between assertions.
module gpio_int_ctrl #(
   parameter int ERR_W    = 42,
   parameter int INF_W    = 50,
   parameter int SK_W     = 15,
   parameter int HOLD_CYC = 8
) (
   input  logic              clk_cpu,
   input  logic              rst_cpu,
   input  logic [ERR_W-1:0]  error_int_cpu,
   input  logic [INF_W-1:0]  inform_int_cpu,
   input  logic [SK_W-1:0]   shake_int_cpu,
   input  logic              cpu_cs,
   input  logic              cpu_wr,
   input  logic [3:0]        cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_rvld,
   output logic [SK_W-1:0]   shake_ack,
   output logic              int_out
);

   localparam int N     = ERR_W + INF_W + SK_W;
   localparam int SK_LO = ERR_W + INF_W;
   localparam int CW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ASSERT = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [N-1:0]    pend, pend_d;
   logic [N-1:0]    mask, mask_d;
   logic [N-1:0]    pulse, mstat, clr;
   logic            en, en_d;
   logic [SK_W-1:0] ack_d;
   logic            wr_pend, wr_mask, wr_ctrl, rd;
   logic [31:0]     rd_pend, rd_mask, rd_mstat, rdata_d;
   logic [6:0]      id_idx;
   logic            req;
   logic [1:0]      state, state_d;
   logic [CW-1:0]   cnt, cnt_d;

   assign pulse   = {shake_int_cpu, inform_int_cpu, error_int_cpu};
   assign mstat   = pend & ~mask;
   assign wr_pend = cpu_cs & cpu_wr & (cpu_addr[3:2] == 2'd0);
   assign wr_mask = cpu_cs & cpu_wr & (cpu_addr[3:2] == 2'd1);
   assign wr_ctrl = cpu_cs & cpu_wr & (cpu_addr == 4'hD);
   assign rd      = cpu_cs & ~cpu_wr;
   assign req     = en & (|mstat);

   // Bits beyond N never match a word lane, so they read 0 and ignore writes.
   always_comb begin
      clr      = '0;
      mask_d   = mask;
      rd_pend  = '0;
      rd_mask  = '0;
      rd_mstat = '0;
      for (int b = 0; b < N; b++) begin
         if ((b >> 5) == int'(cpu_addr[1:0])) begin
            rd_pend[5'(b)]  = pend[b];
            rd_mask[5'(b)]  = mask[b];
            rd_mstat[5'(b)] = mstat[b];
            if (wr_pend) clr[b] = cpu_wdata[5'(b)];
            if (wr_mask) mask_d[b] = cpu_wdata[5'(b)];
         end
      end
   end

   // Set wins over a same-cycle clear.
   assign pend_d = (pend & ~clr) | pulse;
   assign ack_d  = clr[N-1:SK_LO] & pend[N-1:SK_LO] & ~pulse[N-1:SK_LO];
   assign en_d   = wr_ctrl ? cpu_wdata[0] : en;

   always_comb begin
      id_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mstat[i]) id_idx = 7'(i);
      end
   end

   always_comb begin
      rdata_d = '0;
      case (cpu_addr[3:2])
         2'd0: rdata_d = rd_pend;
         2'd1: rdata_d = rd_mask;
         2'd2: rdata_d = rd_mstat;
         default: begin
            case (cpu_addr[1:0])
               2'd0:    rdata_d = {|mstat, 24'd0, id_idx};
               2'd1:    rdata_d = {31'd0, en};
               default: rdata_d = '0;
            endcase
         end
      endcase
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         ST_IDLE: begin
            if (req) state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            if (!req) begin
               state_d = ST_HOLD;
               cnt_d   = CW'(HOLD_CYC - 1);
            end
         end
         ST_HOLD: begin
            if (cnt != '0) cnt_d = cnt - 1'b1;
            else           state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_cpu or posedge rst_cpu) begin
      if (rst_cpu) begin
         pend      <= '0;
         mask      <= '1;
         en        <= 1'b0;
         cpu_rdata <= '0;
         cpu_rvld  <= 1'b0;
         shake_ack <= '0;
         state     <= ST_IDLE;
         cnt       <= '0;
         int_out   <= 1'b0;
      end else begin
         pend      <= pend_d;
         mask      <= mask_d;
         en        <= en_d;
         cpu_rvld  <= rd;
         shake_ack <= ack_d;
         state     <= state_d;
         cnt       <= cnt_d;
         int_out   <= (state_d == ST_ASSERT);
         if (rd) cpu_rdata <= rdata_d;
      end
   end

endmodule

// File: tb/tb_gpio_int_ctrl.sv
// Directed bench for gpio_int_ctrl: pending/mask/ID registers, shake acks and the
// interrupt hold-off FSM, with hand-computed expectations.
module tb_gpio_int_ctrl;

   localparam int ERR_W = 42;
   localparam int INF_W = 50;
   localparam int SK_W  = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ERR_W-1:0]  error_v = '0;
   logic [INF_W-1:0]  inform_v = '0;
   logic [SK_W-1:0]   shake_v = '0;
   logic              cpu_cs = 1'b0;
   logic              cpu_wr = 1'b0;
   logic [3:0]        cpu_addr = '0;
   logic [31:0]       cpu_wdata = '0;
   logic [31:0]       cpu_rdata;
   logic              cpu_rvld;
   logic [SK_W-1:0]   shake_ack;
   logic              int_out;

   int n_checks = 0;
   int n_fail   = 0;
   int lo;

   gpio_int_ctrl #(
      .ERR_W(ERR_W), .INF_W(INF_W), .SK_W(SK_W), .HOLD_CYC(8)
   ) dut (
      .clk_cpu(clk), .rst_cpu(rst),
      .error_int_cpu(error_v), .inform_int_cpu(inform_v), .shake_int_cpu(shake_v),
      .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_rvld(cpu_rvld), .shake_ack(shake_ack), .int_out(int_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      cpu_cs = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
      tick();
      cpu_cs = 1'b0; cpu_wr = 1'b0; cpu_wdata = '0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
      cpu_cs = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
      tick();
      cpu_cs = 1'b0;
      check({tag, "_rvld"}, 32'(cpu_rvld), 32'd1);
      check(tag, cpu_rdata, exp);
   endtask

   initial begin
      // 1: reset state, then first interrupt
      tick(); tick(); tick();
      check("rst_int", 32'(int_out), 32'd0);
      check("rst_rvld", 32'(cpu_rvld), 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_ack", 32'(shake_ack), 32'd0);
      rst = 1'b0;
      tick();
      rd(4'h4, 32'hFFFF_FFFF, "mask_w0_rst");
      rd(4'h7, 32'h0000_07FF, "mask_w3_rst");
      rd(4'hD, 32'd0, "ctrl_rst");
      rd(4'hE, 32'd0, "type3_w2");
      wr(4'hD, 32'd1);
      wr(4'h4, 32'd0);
      error_v = ERR_W'(1) << 3;
      tick();
      error_v = '0;
      check("t1_int_p1", 32'(int_out), 32'd0);
      tick();
      check("t1_int_p2", 32'(int_out), 32'd1);
      rd(4'h0, 32'h0000_0008, "t1_pend");
      rd(4'hC, 32'h8000_0003, "t1_id");
      rd(4'h8, 32'h0000_0008, "t1_mstat");

      // 2: lowest-index ID and deassert
      wr(4'h5, 32'd0);
      wr(4'h0, 32'h0000_0008);
      repeat (12) tick();
      check("t2_idle", 32'(int_out), 32'd0);
      error_v = ERR_W'(1) << 5;
      inform_v = INF_W'(1);
      tick();
      error_v = '0; inform_v = '0;
      tick();
      check("t2_int_on", 32'(int_out), 32'd1);
      rd(4'hC, 32'h8000_0005, "t2_id5");
      wr(4'h0, 32'h0000_0020);
      rd(4'hC, 32'h8000_002A, "t2_id42");
      wr(4'h1, 32'h0000_0400);
      check("t2_int_lag", 32'(int_out), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("t2_int_low", 32'(int_out), 32'd0);
      end
      rd(4'hC, 32'd0, "t2_id_none");

      // 3: set wins over same-cycle W1C
      error_v = ERR_W'(1) << 10;
      tick();
      error_v = '0;
      tick();
      check("t3_int_on", 32'(int_out), 32'd1);
      error_v = ERR_W'(1) << 10;
      wr(4'h0, 32'h0000_0400);
      error_v = '0;
      rd(4'h0, 32'h0000_0400, "t3_pend");
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_int_kept", 32'(int_out), 32'd1);
      end
      wr(4'h0, 32'h0000_0400);
      repeat (12) tick();

      // 4: shake acknowledge
      shake_v = SK_W'(1) << 2;
      tick();
      shake_v = '0;
      rd(4'h2, 32'h4000_0000, "t4_pend_w2");
      rd(4'hA, 32'd0, "t4_mstat_w2");
      wr(4'h2, 32'h4000_0000);
      check("t4_ack", 32'(shake_ack), 32'h0000_0004);
      tick();
      check("t4_ack_1cyc", 32'(shake_ack), 32'd0);
      wr(4'h2, 32'h4000_0000);
      check("t4_ack_rep", 32'(shake_ack), 32'd0);
      tick();
      check("t4_ack_rep2", 32'(shake_ack), 32'd0);
      shake_v = SK_W'(1) << 1;
      tick();
      shake_v = SK_W'(1) << 1;
      wr(4'h2, 32'h2000_0000);
      shake_v = '0;
      check("t4_ack_kept", 32'(shake_ack), 32'd0);
      rd(4'h2, 32'h2000_0000, "t4_pend_kept");

      // 5: hold-off after deassert, then reset mid-assert
      error_v = ERR_W'(1) << 7;
      tick();
      error_v = '0;
      tick();
      check("t5_int_on", 32'(int_out), 32'd1);
      wr(4'h0, 32'h0000_0080);
      check("t5_int_lag", 32'(int_out), 32'd1);
      tick();
      lo = 0;
      if (!int_out) lo++;
      error_v = ERR_W'(1) << 7;
      tick();
      error_v = '0;
      for (int i = 0; i < 20; i++) begin
         if (int_out) break;
         lo++;
         tick();
      end
      check("t5_reassert", 32'(int_out), 32'd1);
      check("t5_low_gap", 32'(lo >= 8 && lo <= 9), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_int", 32'(int_out), 32'd0);
      error_v = ERR_W'(1);
      tick();
      error_v = '0;
      tick();
      rst = 1'b0;
      tick();
      check("t5_rst_int2", 32'(int_out), 32'd0);
      rd(4'h4, 32'hFFFF_FFFF, "t5_mask_w0");
      rd(4'h0, 32'd0, "t5_pend_w0");
      rd(4'hD, 32'd0, "t5_ctrl");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
